rom_arbiter: RTL
================

# rom_arbiter

Two-port arbiter that shares the single combinational program ROM (16 x 32-bit words, low byte used) between two requesters, typically instruction fetch (port 0) and data load (port 1). It accepts at most one read per cycle with a valid/grant handshake, round-robin fairness on conflict, and drives the ROM address from a register. Each read returns one byte with a fixed two-cycle latency, tagged by a per-port valid pulse. It sits between the CPU front end and `rom_module`-style storage.

## Interface

- `ADDR_W`, 32, width of requester and ROM addresses
- `DATA_W`, 8, width of returned data (low bits of ROM word)
- `DEPTH`, 16, number of valid ROM words; addresses >= DEPTH are out of range

- `sys_clk`  input  1  single clock, all state updates on rising edge
- `sys_rst`  input  1  synchronous active-low reset, sampled on `sys_clk` rising edge
- `req0`  input  1  port 0 read request; held with `addr0` until granted
- `addr0`  input  ADDR_W  port 0 read address
- `gnt0`  output  1  port 0 request accepted this cycle (combinational)
- `rvalid0`  output  1  one-cycle pulse: `rdata`/`rerr` belong to port 0
- `req1`, `addr1`, `gnt1`, `rvalid1`  same as port 0, for port 1
- `rdata`  output  DATA_W  shared registered read data
- `rerr`  output  1  qualifies `rvalidX`: address was out of range
- `rom_addr`  output  ADDR_W  registered address to ROM
- `rom_data`  input  32  combinational ROM word for `rom_addr`

## Operation

- Handshake: transfer on port X occurs in a cycle where `reqX && gntX`. Requester must not change `addrX` while `reqX` high and `gntX` low. Dropping `reqX` without grant is legal (request withdrawn, no response).
- Arbitration (combinational, per cycle): only one requester -> grant it. Both -> grant the port not in `last` (round-robin pointer). Neither -> no grant. `gnt0 && gnt1` never both high.
- `last` updates to the granted port on every transfer; unchanged otherwise. Reset value `last` = 1 (port 0 wins first conflict).
- Stage 1 (edge ending handshake cycle): `rom_addr` <= granted address; `tag` <= granted port; `s1_vld` <= 1; `s1_oor` <= (address >= DEPTH), compared on full ADDR_W, no truncation. No transfer: `s1_vld` <= 0, `rom_addr` holds.
- Stage 2 (next edge): if `s1_vld`: `rdata` <= `s1_oor` ? 0 : `rom_data[DATA_W-1:0]`; `rerr` <= `s1_oor`; `rvalid[tag]` <= 1, other `rvalid` <= 0. If not `s1_vld`: both `rvalid` <= 0, `rerr` <= 0, `rdata` holds.
- Pipeline is fully overlapped: one grant per cycle sustained, responses in grant order.
- Reset (`sys_rst` = 0 at an edge): `rom_addr` = 0, `rdata` = 0, `rerr` = 0, `rvalid0` = `rvalid1` = 0, `s1_vld` = 0, `last` = 1. `gnt0`/`gnt1` forced 0 while `sys_rst` low. In-flight reads are discarded; no `rvalid` pulse issued for any read granted before reset.

## Timing

- Grant: same cycle as request (combinational from `req0`, `req1`, `last`, `sys_rst`).
- Latency: handshake in cycle N -> `rom_addr` valid cycle N+1 -> `rvalidX`, `rdata`, `rerr` valid cycle N+2, for exactly one cycle.
- Throughput: 1 read/cycle; alternating service under continuous dual requests.
- Simultaneous events: new grant in the same cycle a response is returned is legal; `rdata` for stage 2 and `rom_addr` for stage 1 update on the same edge independently.
- Reset deasserted at edge E: first grant possible in cycle after E.

## Test plan

- ROM model word i = 0xA0+i. Reset, then `req0`=1, `addr0`=3 one cycle -> `gnt0`=1 that cycle; `rom_addr`=3 next cycle; `rvalid0`=1, `rdata`=0xA3, `rerr`=0 two cycles after; `rvalid1` stays 0.
- `req0`, `req1` held high, `addr0`=1, `addr1`=2, each dropped after its grant -> cycle 0 `gnt0`, cycle 1 `gnt1`; `rvalid0` `rdata`=0xA1 at cycle 2, `rvalid1` `rdata`=0xA2 at cycle 3.
- Both ports request continuously with incrementing addresses for 8 cycles -> grants alternate 0,1,0,1...; 8 responses back-to-back in grant order, no gaps.
- `req1`, `addr1`=16, then `addr1`=0x10000002 -> both responses `rvalid1`=1, `rerr`=1, `rdata`=0x00 (no aliasing to word 0 or 2).
- Grant port 0 (`addr0`=5), pull `sys_rst` low the next cycle for one cycle -> no `rvalid0` ever for that read; all outputs 0 after reset edge; `gnt0` low while reset low.
- `req0`=1 `addr0`=7 raised while port 1 holds `req1` after last service to port 0 -> `gnt1` first, `gnt0` next cycle; `addr0` held stable; port 0 returns 0xA7.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Bus bundle between two ROM requesters, the arbiter and a combinational ROM.
// The slave modport is the arbiter side; master is the requester/ROM side.
interface rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              rerr;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, rerr, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, rerr, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin two-port arbiter in front of a combinational ROM: one grant per
// cycle, registered ROM address, byte response two cycles after the handshake.
module rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    rom_arbiter_if.slave  bus
);
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;

    logic              last_q, last_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              tag_q, tag_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_oor_q, s1_oor_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [1:0]        rvalid_q, rvalid_d;

    // Only the low byte of each ROM word carries data.
    logic              unused_rom_hi;
    assign unused_rom_hi = ^bus.rom_data[31:DATA_W];

    assign req = {bus.req1, bus.req0};

    // last_q names the port served most recently; the other one wins a conflict.
    always_comb begin
        gnt = 2'b00;
        if (sys_rst) begin
            if (req[0] && req[1]) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        sel_addr = gnt[1] ? bus.addr1 : bus.addr0;
    end

    always_comb begin
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        tag_d      = tag_q;
        s1_oor_d   = s1_oor_q;
        s1_vld_d   = 1'b0;
        if (|gnt) begin
            last_d     = gnt[1];
            rom_addr_d = sel_addr;
            tag_d      = gnt[1];
            s1_vld_d   = 1'b1;
            s1_oor_d   = (sel_addr >= ADDR_W'(DEPTH));
        end

        rvalid_d = 2'b00;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        if (s1_vld_q) begin
            rdata_d         = s1_oor_q ? '0 : bus.rom_data[DATA_W-1:0];
            rerr_d          = s1_oor_q;
            rvalid_d[tag_q] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            last_q     <= 1'b1;
            rom_addr_q <= '0;
            tag_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_oor_q   <= 1'b0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
            rvalid_q   <= 2'b00;
        end else begin
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            tag_q      <= tag_d;
            s1_vld_q   <= s1_vld_d;
            s1_oor_q   <= s1_oor_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.gnt0     = gnt[0];
    assign bus.gnt1     = gnt[1];
    assign bus.rom_addr = rom_addr_q;
    assign bus.rdata    = rdata_q;
    assign bus.rerr     = rerr_q;
    assign bus.rvalid0  = rvalid_q[0];
    assign bus.rvalid1  = rvalid_q[1];
endmodule
